// File: rtl/csa_tree_add_if.sv
// Valid/ready bus for the multi-operand carry-save adder: operand/tag input
// channel and sum/tag output channel.
interface csa_tree_add_if #(
  parameter int unsigned N_OPS = 8,
  parameter int unsigned W     = 32,
  parameter int unsigned OUT_W = W + $clog2(N_OPS),
  parameter int unsigned TAG_W = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [N_OPS*W-1:0]     in_ops;
  logic                   in_acc;
  logic [TAG_W-1:0]       in_tag;
  logic                   out_valid;
  logic                   out_ready;
  logic [OUT_W-1:0]       out_sum;
  logic [TAG_W-1:0]       out_tag;

  modport master (
    output in_valid, in_ops, in_acc, in_tag, out_ready,
    input  in_ready, out_valid, out_sum, out_tag
  );

  modport slave (
    input  in_valid, in_ops, in_acc, in_tag, out_ready,
    output in_ready, out_valid, out_sum, out_tag
  );
endinterface

// File: rtl/csa_tree_add.sv
// Pipelined N-operand adder: 5:3 counter tree down to carry-save pair, CPA at
// the output rank, optional running accumulator, in-order valid/ready flow.
module csa_tree_add #(
  parameter int unsigned N_OPS       = 8,
  parameter int unsigned W           = 32,
  parameter int unsigned OUT_W       = W + $clog2(N_OPS),
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned TAG_W       = 4,
  parameter string       ACC_EN      = "FALSE"
) (
  input  logic           clk,
  input  logic           rst_n,
  csa_tree_add_if.slave  bus
);

  localparam int unsigned MID    = PIPE_STAGES - 1;
  localparam int unsigned N_LVL  = N_OPS;
  localparam bit          ACC_ON = (ACC_EN == "TRUE");

  typedef logic [OUT_W-1:0] row_t;

  typedef struct packed {
    row_t             s;
    row_t             c;
    logic [TAG_W-1:0] tag;
    logic             acc;
  } slot_t;

  // Column-wise 5:3 counter over five rows; count bits land at weights 1, 2, 4.
  function automatic logic [3*OUT_W-1:0] cnt53(input row_t a, input row_t b,
                                               input row_t c, input row_t d,
                                               input row_t e);
    row_t       s;
    row_t       t;
    row_t       u;
    logic [2:0] cnt;
    s = '0;
    t = '0;
    u = '0;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      cnt  = 3'(a[i]) + 3'(b[i]) + 3'(c[i]) + 3'(d[i]) + 3'(e[i]);
      s[i] = cnt[0];
      t[i] = cnt[1];
      u[i] = cnt[2];
    end
    return {row_t'(u << 2), row_t'(t << 1), s};
  endfunction

  function automatic logic [2*OUT_W-1:0] fa32(input row_t a, input row_t b, input row_t c);
    row_t s;
    row_t cy;
    s  = a ^ b ^ c;
    cy = (a & b) | (a & c) | (b & c);
    return {row_t'(cy << 1), s};
  endfunction

  // Reduce all operand rows level by level until a carry-save pair remains.
  function automatic logic [2*OUT_W-1:0] reduce(input logic [N_OPS*W-1:0] ops);
    row_t        cur [N_OPS];
    row_t        nxt [N_OPS];
    int unsigned n;
    int unsigned m;
    int unsigned base;
    for (int unsigned k = 0; k < N_OPS; k++) begin
      cur[k] = OUT_W'(ops[k*W +: W]);
      nxt[k] = '0;
    end
    n = N_OPS;
    for (int unsigned l = 0; l < N_LVL; l++) begin
      if (n > 2) begin
        for (int unsigned k = 0; k < N_OPS; k++) nxt[k] = '0;
        m = 0;
        for (int unsigned g = 0; g < N_OPS / 5; g++) begin
          if (5 * g + 5 <= n) begin
            {nxt[m+2], nxt[m+1], nxt[m]} = cnt53(cur[5*g], cur[5*g+1], cur[5*g+2],
                                                 cur[5*g+3], cur[5*g+4]);
            m = m + 3;
          end
        end
        base = 5 * (n / 5);
        // Leftover rows: pass singles/pairs through, use a 3:2 cell for three.
        case (n - base)
          1: begin
            nxt[m] = cur[base];
            m      = m + 1;
          end
          2: begin
            nxt[m]   = cur[base];
            nxt[m+1] = cur[base+1];
            m        = m + 2;
          end
          3: begin
            {nxt[m+1], nxt[m]} = fa32(cur[base], cur[base+1], cur[base+2]);
            m                  = m + 2;
          end
          4: begin
            {nxt[m+1], nxt[m]} = fa32(cur[base], cur[base+1], cur[base+2]);
            nxt[m+2]           = cur[base+3];
            m                  = m + 3;
          end
          default: ;
        endcase
        cur = nxt;
        n   = m;
      end
    end
    return {cur[1], cur[0]};
  endfunction

  logic                   adv;
  logic [2*OUT_W-1:0]     red;
  slot_t                  in_slot;
  slot_t                  fin;
  logic                   fin_v;

  row_t                   cpa_sum;
  row_t                   acc_nxt;
  row_t                   acc_q,       acc_d;
  row_t                   out_sum_q,   out_sum_d;
  logic [TAG_W-1:0]       out_tag_q,   out_tag_d;
  logic                   out_valid_q, out_valid_d;

  // The whole pipeline moves together; a held output freezes every rank.
  assign adv = ~out_valid_q | bus.out_ready;

  always_comb begin
    red         = reduce(bus.in_ops);
    in_slot.s   = red[OUT_W-1:0];
    in_slot.c   = red[2*OUT_W-1:OUT_W];
    in_slot.tag = bus.in_tag;
    in_slot.acc = bus.in_acc;
  end

  generate
    if (MID > 0) begin : g_mid
      slot_t           mid_q [MID];
      slot_t           mid_d [MID];
      logic [MID-1:0]  mv_q;
      logic [MID-1:0]  mv_d;

      always_comb begin
        mid_d = mid_q;
        mv_d  = mv_q;
        if (adv) begin
          mid_d[0] = in_slot;
          mv_d[0]  = bus.in_valid;
          for (int unsigned i = 1; i < MID; i++) begin
            mid_d[i] = mid_q[i-1];
            mv_d[i]  = mv_q[i-1];
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < MID; i++) mid_q[i] <= '0;
          mv_q <= '0;
        end else begin
          mid_q <= mid_d;
          mv_q  <= mv_d;
        end
      end

      assign fin   = mid_q[MID-1];
      assign fin_v = mv_q[MID-1];
    end else begin : g_nomid
      assign fin   = in_slot;
      assign fin_v = bus.in_valid;
    end
  endgenerate

  // Output rank: CPA, accumulator update only for a valid slot that loads.
  always_comb begin
    cpa_sum     = fin.s + fin.c;
    acc_nxt     = (ACC_ON && fin.acc) ? row_t'(acc_q + cpa_sum) : cpa_sum;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_tag_d   = out_tag_q;
    acc_d       = acc_q;
    if (adv) begin
      out_valid_d = fin_v;
      if (fin_v) begin
        out_sum_d = acc_nxt;
        out_tag_d = fin.tag;
        if (ACC_ON) acc_d = acc_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_tag_q   <= '0;
      acc_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_tag_q   <= out_tag_d;
      acc_q       <= acc_d;
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_tag   = out_tag_q;

endmodule

// File: tb/tb_csa_tree_add.sv
// Scoreboard bench for csa_tree_add: directed accumulator/flow tests on an
// 8x8 instance plus random-operand sweeps over operand count and depth.
module tb_csa_tree_add;

  localparam int unsigned MP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic sw_rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // ---------------- main instance: N_OPS=8, W=8, OUT_W=11, 2 ranks, accumulator
  csa_tree_add_if #(.N_OPS(8), .W(8), .OUT_W(11), .TAG_W(4)) mif ();
  csa_tree_add #(.N_OPS(8), .W(8), .OUT_W(11), .PIPE_STAGES(MP), .TAG_W(4),
                 .ACC_EN("TRUE")) dut (.clk(clk), .rst_n(rst_n), .bus(mif));

  typedef struct {
    logic [10:0] sum;
    logic [3:0]  tag;
    int          cyc;
  } exp_t;

  exp_t        mq[$];
  exp_t        me;
  bit          lat_chk;
  bit          hold_v;
  logic [10:0] hold_sum;
  logic [3:0]  hold_tag;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("in_ready", 64'(mif.in_ready), 64'(!mif.out_valid || mif.out_ready));
      if (hold_v) begin
        check("hold_valid", 64'(mif.out_valid), 64'(1));
        check("hold_sum", 64'(mif.out_sum), 64'(hold_sum));
        check("hold_tag", 64'(mif.out_tag), 64'(hold_tag));
      end
      hold_v   = mif.out_valid && !mif.out_ready;
      hold_sum = mif.out_sum;
      hold_tag = mif.out_tag;
      if (mif.out_valid) begin
        if (mq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out: got valid sum %0h tag %0h expected no output",
                   mif.out_sum, mif.out_tag);
        end else if (mif.out_ready) begin
          me = mq.pop_front();
          check("out_sum", 64'(mif.out_sum), 64'(me.sum));
          check("out_tag", 64'(mif.out_tag), 64'(me.tag));
          if (lat_chk) check("latency", 64'(cyc - me.cyc), 64'(MP));
        end
      end
    end
  end

  function automatic logic [63:0] mk(input logic [7:0] base, input logic [7:0] step);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[k*8 +: 8] = base + 8'(k) * step;
    return r;
  endfunction

  task automatic send(input logic [63:0] ops, input logic acc, input logic [3:0] tag,
                      input logic [10:0] exp);
    int n;
    n = 0;
    mif.in_valid = 1'b1;
    mif.in_ops   = ops;
    mif.in_acc   = acc;
    mif.in_tag   = tag;
    do begin
      @(negedge clk);
      n++;
    end while (!mif.in_ready && n < 100);
    check("accept", 64'(mif.in_ready), 64'(1));
    if (mif.in_ready) mq.push_back('{exp, tag, cyc});
    @(posedge clk);
    #1;
    mif.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (mq.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", 64'(mq.size()), 64'(0));
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- sweep instances: ACC off, N_OPS in {3,5,17}, depth in {1,4}
  for (genvar g = 0; g < 6; g++) begin : g_sw
    localparam int unsigned SN  = (g < 2) ? 3 : ((g < 4) ? 5 : 17);
    localparam int unsigned SP  = (g % 2 == 0) ? 1 : 4;
    localparam int unsigned SOW = 8 + $clog2(SN);

    csa_tree_add_if #(.N_OPS(SN), .W(8), .OUT_W(SOW), .TAG_W(4)) sif ();
    csa_tree_add #(.N_OPS(SN), .W(8), .OUT_W(SOW), .PIPE_STAGES(SP), .TAG_W(4),
                   .ACC_EN("FALSE")) sdut (.clk(clk), .rst_n(sw_rst_n), .bus(sif));

    typedef struct {
      logic [SOW-1:0] sum;
      logic [3:0]     tag;
      int             cyc;
    } sexp_t;

    sexp_t q[$];
    sexp_t se;
    bit    lat;
    bit    rnd;
    bit    done;

    initial begin : drv
      logic [SN*8-1:0] ops;
      logic [SOW-1:0]  s;
      int              n;
      sif.in_valid = 1'b0;
      sif.in_ops   = '0;
      sif.in_acc   = 1'b0;
      sif.in_tag   = '0;
      lat  = 1'b1;
      rnd  = 1'b0;
      done = 1'b0;
      wait (sw_rst_n === 1'b1);
      @(posedge clk);
      #1;
      for (int t = 0; t < 32; t++) begin
        if (t == 12) begin
          n = 0;
          while (q.size() != 0 && n < 100) begin @(posedge clk); n++; end
          #1;
          lat = 1'b0;
          rnd = 1'b1;
        end
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        s = '0;
        for (int k = 0; k < int'(SN); k++) begin
          ops[k*8 +: 8] = 8'($urandom);
          s             = s + SOW'(ops[k*8 +: 8]);
        end
        sif.in_valid = 1'b1;
        sif.in_ops   = ops;
        sif.in_tag   = 4'(t);
        n = 0;
        do begin @(negedge clk); n++; end while (!sif.in_ready && n < 100);
        check($sformatf("sw%0d_accept", g), 64'(sif.in_ready), 64'(1));
        if (sif.in_ready) q.push_back('{s, 4'(t), cyc});
        @(posedge clk);
        #1;
        sif.in_valid = 1'b0;
      end
      rnd = 1'b0;
      n   = 0;
      while (q.size() != 0 && n < 300) begin @(posedge clk); n++; end
      #1;
      check($sformatf("sw%0d_drain", g), 64'(q.size()), 64'(0));
      done = 1'b1;
    end

    initial begin : rdy
      sif.out_ready = 1'b1;
      forever begin
        @(posedge clk);
        #1;
        sif.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end

    always @(negedge clk) begin
      if (sw_rst_n === 1'b1 && sif.out_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sw%0d_spurious: got valid sum %0h expected no output", g,
                   sif.out_sum);
        end else if (sif.out_ready) begin
          se = q.pop_front();
          check($sformatf("sw%0d_sum", g), 64'(sif.out_sum), 64'(se.sum));
          check($sformatf("sw%0d_tag", g), 64'(sif.out_tag), 64'(se.tag));
          if (lat) check($sformatf("sw%0d_latency", g), 64'(cyc - se.cyc), 64'(SP));
        end
      end
    end
  end

  // ---------------- directed sequence on the main instance
  initial begin
    int n;
    rst_n         = 1'b0;
    sw_rst_n      = 1'b0;
    mif.in_valid  = 1'b0;
    mif.in_ops    = '0;
    mif.in_acc    = 1'b0;
    mif.in_tag    = '0;
    mif.out_ready = 1'b1;
    lat_chk       = 1'b1;
    hold_v        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(mif.out_valid), 64'(0));
    check("rst_out_sum", 64'(mif.out_sum), 64'(0));
    check("rst_out_tag", 64'(mif.out_tag), 64'(0));
    rst_n    = 1'b1;
    sw_rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single all-FF transaction
    send(mk(8'hFF, 8'h00), 1'b0, 4'h5, 11'h7F8);
    drain();

    // 2: back-to-back, operand k = i+k, sum = 8i+28
    for (int i = 0; i < 8; i++) send(mk(8'(i), 8'd1), 1'b0, 4'(i), 11'(8 * i + 28));
    drain();

    // 3: stalled output with three transactions queued behind it
    lat_chk       = 1'b0;
    mif.out_ready = 1'b0;
    fork
      begin
        send(mk(8'd2, 8'd0), 1'b0, 4'h1, 11'd16);
        send(mk(8'd3, 8'd0), 1'b0, 4'h2, 11'd24);
        send(mk(8'd4, 8'd0), 1'b0, 4'h3, 11'd32);
      end
      begin
        repeat (7) @(posedge clk);
        #1;
        mif.out_ready = 1'b1;
      end
    join
    drain();
    lat_chk = 1'b1;

    // 4: accumulate and wrap at 2^11
    send(mk(8'd1, 8'd0), 1'b0, 4'h6, 11'd8);
    send(mk(8'd1, 8'd0), 1'b1, 4'h7, 11'd16);
    send(mk(8'hFF, 8'd0), 1'b0, 4'h8, 11'd2040);
    send(mk(8'hFF, 8'd0), 1'b1, 4'h9, 11'd2032);
    drain();

    // 5: reset pulse between edges with two transactions in flight
    send(mk(8'd1, 8'd0), 1'b0, 4'hA, 11'd8);
    send(mk(8'd2, 8'd0), 1'b0, 4'hB, 11'd16);
    rst_n = 1'b0;
    #1;
    check("rst_drop_valid", 64'(mif.out_valid), 64'(0));
    mq.delete();
    hold_v = 1'b0;
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    send(mk(8'd1, 8'd0), 1'b1, 4'hC, 11'd8);
    drain();

    n = 0;
    while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done &&
             g_sw[4].done && g_sw[5].done) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    check("sweep_done", 64'(g_sw[0].done && g_sw[1].done && g_sw[2].done &&
                            g_sw[3].done && g_sw[4].done && g_sw[5].done), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
